// File: rtl/sd_cmd_card_responder_if.sv
// CMD-line and response-request bundle for the card-side SD command responder.
// slave = the responder itself, master = host line model / user logic.
interface sd_cmd_card_responder_if;
    localparam int unsigned CMD_W = 40;
    localparam int unsigned RSP_W = 128;

    logic             cmd_dat_i;
    logic             cmd_out_o;
    logic             cmd_oe_o;
    logic [CMD_W-1:0] CMD_RX_OUT;
    logic             CMD_VALID;
    logic [1:0]       CMD_ERR;
    logic             RSP_REQ_IN;
    logic [1:0]       RSP_LEN_IN;
    logic [RSP_W-1:0] RSP_IN;
    logic             RSP_ACK_OUT;

    modport slave (
        input  cmd_dat_i, RSP_REQ_IN, RSP_LEN_IN, RSP_IN,
        output cmd_out_o, cmd_oe_o, CMD_RX_OUT, CMD_VALID, CMD_ERR, RSP_ACK_OUT
    );

    modport master (
        output cmd_dat_i, RSP_REQ_IN, RSP_LEN_IN, RSP_IN,
        input  cmd_out_o, cmd_oe_o, CMD_RX_OUT, CMD_VALID, CMD_ERR, RSP_ACK_OUT
    );
endinterface

// File: rtl/sd_cmd_card_responder.sv
// Card-side SD CMD endpoint: deserializes and checks 48-bit host commands,
// then serializes a 48-bit short or 136-bit long response onto the CMD line.
module sd_cmd_card_responder #(
    parameter int unsigned NCR_CYCLES   = 2,
    parameter int unsigned RSP_WAIT_MAX = 64
) (
    input  logic                  SD_CLK_IN,
    input  logic                  RST_IN,
    sd_cmd_card_responder_if.slave bus
);
    localparam int unsigned CNT_W   = $clog2(RSP_WAIT_MAX + 1);
    localparam int unsigned CMD_W   = 40;
    localparam int unsigned CRC_W   = 7;
    localparam int unsigned TX_W    = 136;
    localparam int unsigned BCNT_W  = 8;

    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RSP, TX, DONE} state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CRC_W-1:0]    rx_crc_q, rx_crc_d;
    logic [CMD_W-1:0]    rx_sr_q, rx_sr_d;
    logic                end_bit_q, end_bit_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [TX_W-1:0]     tx_sr_q, tx_sr_d;
    logic                tx_long_q, tx_long_d;
    logic                cmd_out_q, cmd_out_d;
    logic                cmd_oe_q, cmd_oe_d;
    logic [CMD_W-1:0]    cmd_rx_q, cmd_rx_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_err_q, cmd_err_d;
    logic                rsp_ack_q, rsp_ack_d;

    logic [BCNT_W-1:0]   rx_n;
    logic [BCNT_W-1:0]   tx_len;
    logic [1:0]          chk_err;
    logic                len_ok;
    logic                len_none;
    logic [TX_W-1:0]     tx_frame;

    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [CRC_W-1:0] crc7_40(input logic [CMD_W-1:0] d);
        logic [CRC_W-1:0] c;
        c = '0;
        for (int i = CMD_W - 1; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        rx_sr_d     = rx_sr_q;
        end_bit_d   = end_bit_q;
        wait_cnt_d  = wait_cnt_q;
        tx_sr_d     = tx_sr_q;
        tx_long_d   = tx_long_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        cmd_rx_d    = cmd_rx_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = cmd_err_q;
        rsp_ack_d   = 1'b0;

        rx_n     = bit_cnt_q + 8'd1;
        tx_len   = tx_long_q ? 8'd136 : 8'd48;
        chk_err  = {~end_bit_q, (crc_q != rx_crc_q)};
        len_ok   = bus.RSP_REQ_IN && ((bus.RSP_LEN_IN == 2'b01) || (bus.RSP_LEN_IN == 2'b10));
        len_none = bus.RSP_REQ_IN && ((bus.RSP_LEN_IN == 2'b00) || (bus.RSP_LEN_IN == 2'b11));
        // Long frames carry the CID/CSD CRC inline; bit 0 slot is overwritten by the end bit.
        tx_frame = (bus.RSP_LEN_IN == 2'b10)
                 ? {8'h3F, bus.RSP_IN}
                 : {2'b00, bus.RSP_IN[37:0], crc7_40({2'b00, bus.RSP_IN[37:0]}), 1'b1, 88'd0};

        case (state_q)
            IDLE: begin
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
                if (!bus.cmd_dat_i) begin
                    state_d   = RX;
                    bit_cnt_d = 8'd1;
                    crc_d     = crc7_step(7'd0, 1'b0);
                    rx_sr_d   = '0;
                end
            end
            RX: begin
                bit_cnt_d = rx_n;
                if (rx_n == 8'd2 && !bus.cmd_dat_i) begin
                    state_d = IDLE;
                end else if (rx_n <= 8'd40) begin
                    crc_d   = crc7_step(crc_q, bus.cmd_dat_i);
                    rx_sr_d = {rx_sr_q[CMD_W-2:0], bus.cmd_dat_i};
                end else if (rx_n <= 8'd47) begin
                    rx_crc_d = {rx_crc_q[CRC_W-2:0], bus.cmd_dat_i};
                end else begin
                    end_bit_d = bus.cmd_dat_i;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                cmd_valid_d = 1'b1;
                cmd_rx_d    = rx_sr_q;
                cmd_err_d   = chk_err;
                if (chk_err != 2'b00) begin
                    state_d = IDLE;
                end else begin
                    state_d    = WAIT_RSP;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            WAIT_RSP: begin
                if (wait_cnt_q >= CNT_W'(RSP_WAIT_MAX)) begin
                    state_d = IDLE;
                end else if (len_ok && wait_cnt_q >= CNT_W'(NCR_CYCLES)) begin
                    state_d   = TX;
                    tx_long_d = (bus.RSP_LEN_IN == 2'b10);
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_frame[TX_W-1];
                    tx_sr_d   = {tx_frame[TX_W-2:0], 1'b0};
                    bit_cnt_d = 8'd1;
                end else if (len_none) begin
                    rsp_ack_d = 1'b1;
                    state_d   = IDLE;
                end else if (!bus.cmd_dat_i) begin
                    state_d   = RX;
                    bit_cnt_d = 8'd1;
                    crc_d     = crc7_step(7'd0, 1'b0);
                    rx_sr_d   = '0;
                end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            TX: begin
                if (bit_cnt_q == tx_len) begin
                    state_d   = DONE;
                    cmd_oe_d  = 1'b0;
                    cmd_out_d = 1'b1;
                end else begin
                    cmd_out_d = (bit_cnt_q == tx_len - 8'd1) ? 1'b1 : tx_sr_q[TX_W-1];
                    tx_sr_d   = {tx_sr_q[TX_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end
            end
            DONE: begin
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
                rsp_ack_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            rx_crc_q    <= '0;
            rx_sr_q     <= '0;
            end_bit_q   <= 1'b0;
            wait_cnt_q  <= '0;
            tx_sr_q     <= '0;
            tx_long_q   <= 1'b0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_rx_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 2'b00;
            rsp_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            rx_sr_q     <= rx_sr_d;
            end_bit_q   <= end_bit_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_sr_q     <= tx_sr_d;
            tx_long_q   <= tx_long_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
            cmd_rx_q    <= cmd_rx_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            rsp_ack_q   <= rsp_ack_d;
        end
    end

    assign bus.cmd_out_o   = cmd_out_q;
    assign bus.cmd_oe_o    = cmd_oe_q;
    assign bus.CMD_RX_OUT  = cmd_rx_q;
    assign bus.CMD_VALID   = cmd_valid_q;
    assign bus.CMD_ERR     = cmd_err_q;
    assign bus.RSP_ACK_OUT = rsp_ack_q;
endmodule

// File: doc/sd_cmd_card_responder.md
Name: sd_cmd_card_responder

Overview:
Card-side endpoint of the SD CMD line. The block deserializes 48-bit host commands on cmd_dat_i and checks start, transmission, CRC7 and end bits. It then serializes an R1/R3/R6/R7 short response (48 bits) or an R2 long response (136 bits) back onto the shared CMD line. It is the counterpart of the host command serializer: a bus-functional card model for the controller testbench, and the CMD front end of the device-mode core.

Parameters:
NCR_CYCLES, 2, minimum clocks between the command end bit and the response start bit (SD N_CR, must be >= 2)
RSP_WAIT_MAX, 64, clocks to wait for RSP_REQ_IN before abandoning the response

Ports:
SD_CLK_IN  in  1  SD clock; all logic on its rising edge
RST_IN  in  1  synchronous active-high reset
cmd_dat_i  in  1  sampled CMD line
cmd_out_o  out  1  CMD line drive value
cmd_oe_o  out  1  CMD line output enable; 1 = drive
CMD_RX_OUT  out  40  last received command bits [47:8]: start, dir, index[5:0], arg[31:0]
CMD_VALID  out  1  one-cycle pulse; a framed command has been received
CMD_ERR  out  2  qualified by CMD_VALID; [0] = CRC7 mismatch, [1] = end bit was 0
RSP_REQ_IN  in  1  level; user requests a response
RSP_LEN_IN  in  2  00 none, 01 short (48), 10 long (136), 11 treated as 00
RSP_IN  in  128  short: [37:0] = index + 32-bit payload; long: [127:1] = CID/CSD including its internal CRC7, [0] ignored
RSP_ACK_OUT  out  1  one-cycle pulse; response end bit sent, or request completed with no response

Behaviour:
- Reset (RST_IN = 1 at a clock edge) forces state IDLE and drives cmd_oe_o=0, cmd_out_o=1, CMD_RX_OUT=0, CMD_VALID=0, CMD_ERR=0, RSP_ACK_OUT=0. The bit counter and CRC register are cleared.
- Reset mid-frame or mid-response takes effect at that same edge; the line is released on the following cycle.
- All outputs are registered.
- States: IDLE, RX, CHECK, WAIT_RSP, TX, DONE.
- IDLE: cmd_oe_o=0. Sampling cmd_dat_i=0 moves to RX with bit count 1; the CRC7 register (x^7+x^3+1) is cleared, then fed.
- RX: shifts one bit per clock.
  - Bit 2 (direction) must be 1; if it is 0, return to IDLE silently with no CMD_VALID.
  - Bits 1..40 feed the CRC; bits 41..47 are captured as the received CRC.
  - On bit 48 (the end bit), go to CHECK.
- CHECK (single cycle):
  - CMD_RX_OUT is updated and CMD_VALID=1, with CMD_ERR set as defined above.
  - If CMD_ERR != 0: go to IDLE and send no response (the card ignores bad commands).
  - Otherwise: go to WAIT_RSP, with the N_CR counter starting at 1.
  - CMD_RX_OUT holds until the next CHECK.
- WAIT_RSP: the counter increments each clock, saturating.
  - Go to TX when counter >= NCR_CYCLES and RSP_REQ_IN=1 and RSP_LEN_IN is 01 or 10.
  - If RSP_REQ_IN=1 with RSP_LEN_IN 00 or 11: pulse RSP_ACK_OUT and go to IDLE.
  - If the counter reaches RSP_WAIT_MAX: go to IDLE with no ACK.
  - If cmd_dat_i=0 (a new host command): abandon the wait and enter RX as from IDLE.
- RSP_LEN_IN and RSP_IN are latched on entry to TX; later changes are ignored.
- TX: cmd_oe_o=1, one bit per clock, and cmd_dat_i is ignored.
  - Short response: 0, 0, RSP_IN[37:0] MSB first, then 7 CRC bits computed over the first 40 sent bits, then end bit 1. Total 48 clocks.
  - Long response: 0, 0, 111111, RSP_IN[127:1] MSB first, then end bit 1. Total 136 clocks; the block computes no CRC.
- DONE (one cycle): cmd_oe_o=0, cmd_out_o=1, RSP_ACK_OUT=1, then go to IDLE.
- Latency: the CHECK cycle is E+1, where E is the end-bit sampling edge. The earliest start bit is driven in cycle E+NCR_CYCLES+1, provided RSP_REQ_IN is already high.
- Back-to-back commands: after DONE, IDLE accepts a start bit on the very next cycle.
- A 0 seen in IDLE is always treated as a start bit; there is no glitch filter.
- Widths: the bit counter is 8 bits. The N_CR/wait counter is wide enough for RSP_WAIT_MAX and saturates.

Test Plan:
- CMD0 frame 0x40_00000000, CRC byte 0x95 -> CMD_VALID pulse at E+1; CMD_RX_OUT=0x4000000000, CMD_ERR=00; no RSP_REQ_IN -> back to IDLE after RSP_WAIT_MAX clocks, cmd_oe_o stays 0.
- CMD8 0x48_000001AA, CRC byte 0x87; RSP_REQ_IN=1, RSP_LEN_IN=01, RSP_IN[37:0]={6'h08, 32'h000001AA} -> start bit driven at E+3 (NCR_CYCLES=2); line shows 0x08_000001AA_13; RSP_ACK_OUT pulses, then cmd_oe_o=0.
- CMD17 0x51_00000000 with CRC byte corrupted to 0x57 -> CMD_VALID with CMD_ERR=01; cmd_oe_o never asserts even if RSP_REQ_IN=1. Same frame with end bit 0 -> CMD_ERR=10.
- CMD2 followed by a long request with RSP_IN=128'hFEDC...0123 -> 136 driven bits: 00, 111111, RSP_IN[127:1], 1; RSP_ACK_OUT exactly 137 clocks after the start bit.
- Direction bit 0 in the frame -> no CMD_VALID. RST_IN asserted at bit 20 of a response -> next cycle cmd_oe_o=0 and outputs at reset values; a following CMD0 is received correctly.
- New start bit during WAIT_RSP -> wait abandoned, no response; the new command is decoded with CMD_VALID.
